// File: rtl/timestamp_capture.sv
// Edge timestamp capture: stamps qualified edges of event_in with current_time,
// buffers them in a FIFO and exposes them to software over AXI4-Lite.
module timestamp_capture #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] current_time,
  input  logic        time_running,
  input  logic        event_in,
  output logic        irq,
  input  logic [11:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [11:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  localparam logic [9:0] A_CONFIG = 10'h000;
  localparam logic [9:0] A_STATUS = 10'h001;
  localparam logic [9:0] A_TS_LO  = 10'h002;
  localparam logic [9:0] A_TS_HI  = 10'h003;
  localparam logic [9:0] A_DROP   = 10'h004;

  logic          enable;
  logic          edge_sel;
  logic          event_d;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [31:0]   shadow;
  logic [31:0]   drop_count;
  logic          overflow;

  logic          fifo_empty;
  logic          fifo_full;
  logic [PW-1:0] count;
  logic [63:0]   head;
  logic [9:0]    wr_word;
  logic [9:0]    rd_word;
  logic          wr_fire;
  logic          rd_fire;
  logic          clear;
  logic          edge_det;
  logic          qualified;
  logic          push;
  logic          pop;
  logic          drop;
  logic          awready_nxt;
  logic [31:0]   rd_data_c;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count      = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];

  assign wr_word = s_axi_awaddr[11:2];
  assign rd_word = s_axi_araddr[11:2];
  assign wr_fire = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire = s_axi_arready && s_axi_arvalid;

  // CLEAR overrides any capture or pop that lands in the same cycle
  assign clear     = wr_fire && (wr_word == A_CONFIG) && s_axi_wdata[2];
  assign edge_det  = edge_sel ? (event_d && !event_in) : (event_in && !event_d);
  assign qualified = edge_det && enable && time_running && !clear;
  assign pop       = rd_fire && (rd_word == A_TS_HI) && !fifo_empty && !clear;
  assign push      = qualified && (!fifo_full || pop);
  assign drop      = qualified && fifo_full && !pop;

  assign awready_nxt = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  // Read data mux, sampled on the address handshake
  always_comb begin
    rd_data_c = 32'h0;
    case (rd_word)
      A_CONFIG: rd_data_c = {30'h0, edge_sel, enable};
      A_STATUS: rd_data_c = {14'h0, fifo_empty, overflow, 7'h0, 9'(count)};
      A_TS_LO:  rd_data_c = fifo_empty ? 32'h0 : head[31:0];
      A_TS_HI:  rd_data_c = shadow;
      A_DROP:   rd_data_c = drop_count;
      default:  rd_data_c = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_d       <= event_in;
      enable        <= 1'b0;
      edge_sel      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      shadow        <= 32'h0;
      drop_count    <= 32'h0;
      overflow      <= 1'b0;
      irq           <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 32'h0;
    end else begin
      event_d       <= event_in;
      s_axi_awready <= awready_nxt;
      s_axi_wready  <= awready_nxt;
      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;

      if (wr_fire)           s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;

      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data_c;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      if (wr_fire && (wr_word == A_CONFIG)) begin
        enable   <= s_axi_wdata[0];
        edge_sel <= s_axi_wdata[1];
      end

      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        shadow     <= 32'h0;
        drop_count <= 32'h0;
        overflow   <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (rd_fire && (rd_word == A_TS_LO))
          shadow <= fifo_empty ? 32'h0 : head[63:32];
        // A new drop wins over a simultaneous write-1-to-clear
        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
        end else if (wr_fire && (wr_word == A_STATUS) && s_axi_wdata[16]) begin
          overflow <= 1'b0;
        end
      end

      irq <= enable && !fifo_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= current_time;
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr[1:0],
                         s_axi_araddr[1:0], s_axi_wdata[31:17], s_axi_wdata[15:3]};

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture: read responses are checked by a
// queue-based scoreboard monitor; handshake/irq levels are checked inline.
module tb_timestamp_capture;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] current_time;
  logic        time_running;
  logic        event_in;
  logic        irq;
  logic [11:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [11:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  timestamp_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .current_time(current_time), .time_running(time_running),
    .event_in(event_in), .irq(irq),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Scoreboard monitor: every completed read beat is matched against the queue head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && s_axi_rvalid && s_axi_rready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got %h, nothing expected", s_axi_rdata);
      end else begin
        e = sb.pop_front();
        if (s_axi_rdata !== e.exp || s_axi_rresp !== 2'b00) begin
          n_fail++;
          $display("FAIL %s: got %h resp %0d, expected %h resp 0", e.name, s_axi_rdata,
                   s_axi_rresp, e.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_level(input string name, input int sel);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel == 0 && s_axi_awready) || (sel == 1 && s_axi_bvalid) ||
          (sel == 2 && s_axi_arready) || (sel == 3 && s_axi_rvalid)) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: timeout, got no handshake, expected one within 20 cycles", name);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    wait_level("aw_handshake", 0);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    wait_level("b_response", 1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input string name);
    sb.push_back('{exp, name});
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    wait_level("ar_handshake", 2);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    wait_level("r_response", 3);
    @(posedge clk); #1;
  endtask

  task automatic edge_at(input logic [63:0] t, input logic lvl);
    current_time = t;
    event_in     = lvl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0;
    current_time = 64'h0; time_running = 1'b0; event_in = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_rdata", 64'(s_axi_rdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    time_running = 1'b1;
    idle(1);
    axi_read(12'h004, 32'h0002_0000, "status_after_reset");
    axi_read(12'h000, 32'h0, "config_after_reset");
    axi_read(12'h010, 32'h0, "drop_after_reset");

    // Capture order, rising edges only
    axi_write(12'h000, 32'h1);
    edge_at(64'd100, 1'b1);
    edge_at(64'd105, 1'b0);
    edge_at(64'd250, 1'b1);
    edge_at(64'd255, 1'b0);
    idle(2);
    check("irq_with_entries", 64'(irq), 64'd1);
    axi_read(12'h004, 32'h0000_0002, "status_two_entries");
    axi_read(12'h008, 32'd100, "ts_lo_first");
    axi_read(12'h00C, 32'd0, "ts_hi_first");
    axi_read(12'h008, 32'd250, "ts_lo_second");
    axi_read(12'h00C, 32'd0, "ts_hi_second");
    axi_read(12'h004, 32'h0002_0000, "status_drained");
    idle(2);
    check("irq_drained", 64'(irq), 64'd0);

    // Falling-edge select
    axi_write(12'h000, 32'h3);
    edge_at(64'd40, 1'b1);
    edge_at(64'd60, 1'b0);
    idle(1);
    axi_read(12'h004, 32'h0000_0001, "status_falling_one");
    axi_read(12'h008, 32'd60, "ts_lo_falling");
    axi_read(12'h00C, 32'd0, "ts_hi_falling");

    // Upper word of the timestamp
    axi_write(12'h000, 32'h1);
    edge_at(64'h1_FFFF_FFF0, 1'b1);
    edge_at(64'h1_FFFF_FFF8, 1'b0);
    idle(1);
    axi_read(12'h008, 32'hFFFF_FFF0, "ts_lo_high");
    axi_read(12'h00C, 32'h0000_0001, "ts_hi_high");
    axi_read(12'h004, 32'h0002_0000, "status_after_high");

    // Gating by timer and ENABLE, then empty reads
    time_running = 1'b0;
    edge_at(64'd500, 1'b1);
    edge_at(64'd510, 1'b0);
    time_running = 1'b1;
    axi_write(12'h000, 32'h0);
    edge_at(64'd520, 1'b1);
    edge_at(64'd530, 1'b0);
    idle(2);
    axi_read(12'h004, 32'h0002_0000, "status_gated");
    check("irq_gated", 64'(irq), 64'd0);
    axi_read(12'h008, 32'd0, "ts_lo_empty");
    axi_read(12'h00C, 32'd0, "ts_hi_empty");
    axi_read(12'h004, 32'h0002_0000, "status_empty_pop");

    // Unmapped space
    axi_read(12'h020, 32'd0, "unmapped_read");
    axi_write(12'h024, 32'hFFFF_FFFF);
    axi_read(12'h000, 32'h0, "config_after_unmapped_write");

    // Overflow: DEPTH+3 rising edges
    axi_write(12'h000, 32'h1);
    for (int i = 0; i < DEPTH + 3; i++) begin
      edge_at(64'(1000 + 10 * i), 1'b1);
      edge_at(64'(1005 + 10 * i), 1'b0);
    end
    idle(1);
    axi_read(12'h004, 32'h0001_0010, "status_full_overflow");
    axi_read(12'h010, 32'd3, "drop_count_three");
    axi_read(12'h008, 32'd1000, "ts_lo_oldest_kept");
    axi_read(12'h00C, 32'd0, "ts_hi_oldest_kept");
    axi_read(12'h004, 32'h0001_000F, "status_after_one_pop");
    edge_at(64'd2000, 1'b1);
    edge_at(64'd2005, 1'b0);
    idle(1);
    axi_read(12'h004, 32'h0001_0010, "status_refilled");
    axi_read(12'h008, 32'd1010, "ts_lo_before_pushpop");

    // Push and pop in the same cycle while full
    sb.push_back('{32'd0, "ts_hi_pushpop"});
    s_axi_araddr  = 12'h00C;
    s_axi_arvalid = 1'b1;
    wait_level("ar_pushpop", 2);
    current_time = 64'd3000;
    event_in     = 1'b1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    wait_level("r_pushpop", 3);
    @(posedge clk); #1;
    edge_at(64'd3005, 1'b0);
    idle(1);
    axi_read(12'h004, 32'h0001_0010, "status_after_pushpop");
    axi_read(12'h010, 32'd3, "drop_after_pushpop");

    // OVERFLOW write-1-to-clear
    axi_write(12'h004, 32'h0001_0000);
    axi_read(12'h004, 32'h0000_0010, "status_overflow_cleared");

    // Read response held under back-pressure
    s_axi_rready = 1'b0;
    sb.push_back('{32'd3, "drop_held_read"});
    s_axi_araddr  = 12'h010;
    s_axi_arvalid = 1'b1;
    wait_level("ar_hold", 2);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rvalid_held", 64'(s_axi_rvalid), 64'd1);
      check("rdata_held", 64'(s_axi_rdata), 64'd3);
      check("no_second_ar", 64'(s_axi_arready), 64'd0);
    end
    @(posedge clk); #1;
    s_axi_rready  = 1'b1;
    s_axi_arvalid = 1'b0;
    idle(2);
    check("rvalid_released", 64'(s_axi_rvalid), 64'd0);

    // Write response held under back-pressure
    s_axi_bready  = 1'b0;
    s_axi_awaddr  = 12'h000;
    s_axi_wdata   = 32'h1;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    wait_level("aw_hold", 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bvalid_held", 64'(s_axi_bvalid), 64'd1);
      check("no_second_aw", 64'(s_axi_awready), 64'd0);
    end
    @(posedge clk); #1;
    s_axi_bready  = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    idle(2);
    check("bvalid_released", 64'(s_axi_bvalid), 64'd0);

    // CLEAR with a simultaneous qualified edge
    s_axi_awaddr  = 12'h000;
    s_axi_wdata   = 32'h5;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    wait_level("aw_clear", 0);
    current_time = 64'd5000;
    event_in     = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    wait_level("b_clear", 1);
    @(posedge clk); #1;
    axi_read(12'h004, 32'h0002_0000, "status_after_clear");
    axi_read(12'h010, 32'd0, "drop_after_clear");
    axi_read(12'h000, 32'h1, "config_after_clear");
    axi_read(12'h00C, 32'd0, "shadow_after_clear");
    check("irq_after_clear", 64'(irq), 64'd0);
    edge_at(64'd5005, 1'b0);
    edge_at(64'd6000, 1'b1);
    idle(2);
    check("irq_after_new_capture", 64'(irq), 64'd1);
    axi_read(12'h004, 32'h0000_0001, "status_new_capture");
    axi_read(12'h008, 32'd6000, "ts_lo_new_capture");
    axi_read(12'h00C, 32'd0, "ts_hi_new_capture");

    idle(2);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
